// File: rtl/datapath_pipelined.sv
// datapath_pipelined
//   Two-stage (ID -> EX/WB) CR16-style datapath: register file, operand
//   muxing with EX->ID forwarding, ALU, writeback mux and a registered
//   status-flag write.
//
//   ID: combinational register read, forwarding and immediate select.
//   EX: registered operands, ALU, writeback mux. The EX instruction retires
//       (GPR / flags write) on the same enabled edge that captures the next
//       ID instruction.
//
// Ports
//   I_CLK, I_RESET          clock, synchronous active-high reset
//   I_ENABLE                0 = stall: hold all state, no retire
//   I_FLUSH                 squash the EX instruction (no retire, valid gated)
//   I_VALID                 ID inputs carry a real instruction
//   I_REG_A/B_SELECT        source register indices
//   I_REG_DEST, I_REG_WRITE destination index and write enable
//   I_IMMEDIATE(_SELECT)    immediate replacing operand A
//   I_OPCODE                ALU opcode (table below)
//   I_FLAGS_WRITE           instruction updates O_STATUS_FLAGS
//   I_REGFILE_DATA(_SELECT) external writeback data, sampled live in EX
//   O_A, O_B                EX-stage ALU operands
//   O_RESULT_BUS            EX-stage writeback value
//   O_RESULT_VALID          EX holds a valid instruction and no flush
//   O_REG_DEST              EX-stage destination index
//   O_STATUS_FLAGS          registered flags {N, Z, F, L, C}
//
// ALU opcodes
//   0 ADD  A+B          C = carry out,  F = signed overflow
//   1 SUB  A-B          C = borrow,     F = signed overflow
//   2 AND  3 OR  4 XOR  5 MOV (result = A)
//   6 SHL  B<<1  7 SHR  B>>1 (logical)  8..15 result = 0
//   For every op: L = (A < B) unsigned, Z = result==0, N = result msb;
//   C and F are 0 for non-arithmetic ops.
module datapath_pipelined #(
  parameter int P_WIDTH    = 16,
  parameter int P_NUM_REGS = 16
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET,
  input  logic                          I_ENABLE,
  input  logic                          I_FLUSH,
  input  logic                          I_VALID,
  input  logic [$clog2(P_NUM_REGS)-1:0] I_REG_A_SELECT,
  input  logic [$clog2(P_NUM_REGS)-1:0] I_REG_B_SELECT,
  input  logic [$clog2(P_NUM_REGS)-1:0] I_REG_DEST,
  input  logic                          I_REG_WRITE,
  input  logic [P_WIDTH-1:0]            I_IMMEDIATE,
  input  logic                          I_IMMEDIATE_SELECT,
  input  logic [3:0]                    I_OPCODE,
  input  logic                          I_FLAGS_WRITE,
  input  logic [P_WIDTH-1:0]            I_REGFILE_DATA,
  input  logic                          I_REGFILE_DATA_SELECT,
  output logic [P_WIDTH-1:0]            O_A,
  output logic [P_WIDTH-1:0]            O_B,
  output logic [P_WIDTH-1:0]            O_RESULT_BUS,
  output logic                          O_RESULT_VALID,
  output logic [$clog2(P_NUM_REGS)-1:0] O_REG_DEST,
  output logic [4:0]                    O_STATUS_FLAGS
);
  localparam int P_SEL_W = $clog2(P_NUM_REGS);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;

  typedef struct packed {
    logic               vld;
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    logic [3:0]         op;
    logic [P_SEL_W-1:0] dest;
    logic               reg_write;
    logic               flags_write;
    logic               data_sel;
  } ex_t;

  ex_t                                ex;
  ex_t                                id;
  logic [P_NUM_REGS-1:0][P_WIDTH-1:0] gpr;
  logic                               fwd_a;
  logic                               fwd_b;
  logic [P_WIDTH-1:0]                 alu_res;
  logic [4:0]                         alu_flags;
  logic [P_WIDTH-1:0]                 result;
  logic [P_WIDTH:0]                   sum;
  logic [P_WIDTH:0]                   diff;
  logic                               c_flag;
  logic                               f_flag;

  // ---------------- ID: read, forward, operand mux ----------------
  // Forwarding keys off EX valid only (not the flush gate), so a squashed
  // writer still feeds an immediately following reader of the same register.
  assign fwd_a = ex.vld & ex.reg_write & (ex.dest == I_REG_A_SELECT);
  assign fwd_b = ex.vld & ex.reg_write & (ex.dest == I_REG_B_SELECT);

  always_comb begin
    id             = '0;
    id.vld         = I_VALID;
    id.a           = I_IMMEDIATE_SELECT ? I_IMMEDIATE
                   : (fwd_a ? result : gpr[I_REG_A_SELECT]);
    id.b           = fwd_b ? result : gpr[I_REG_B_SELECT];
    id.op          = I_OPCODE;
    id.dest        = I_REG_DEST;
    id.reg_write   = I_REG_WRITE;
    id.flags_write = I_FLAGS_WRITE;
    id.data_sel    = I_REGFILE_DATA_SELECT;
  end

  // ---------------- EX: ALU and writeback mux ----------------
  assign sum  = {1'b0, ex.a} + {1'b0, ex.b};
  assign diff = {1'b0, ex.a} - {1'b0, ex.b};

  always_comb begin
    alu_res = '0;
    c_flag  = 1'b0;
    f_flag  = 1'b0;
    case (ex.op)
      OP_ADD: begin
        alu_res = sum[P_WIDTH-1:0];
        c_flag  = sum[P_WIDTH];
        f_flag  = (ex.a[P_WIDTH-1] == ex.b[P_WIDTH-1]) &&
                  (sum[P_WIDTH-1] != ex.a[P_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[P_WIDTH-1:0];
        c_flag  = diff[P_WIDTH];  // borrow
        f_flag  = (ex.a[P_WIDTH-1] != ex.b[P_WIDTH-1]) &&
                  (diff[P_WIDTH-1] != ex.a[P_WIDTH-1]);
      end
      OP_AND:  alu_res = ex.a & ex.b;
      OP_OR:   alu_res = ex.a | ex.b;
      OP_XOR:  alu_res = ex.a ^ ex.b;
      OP_MOV:  alu_res = ex.a;
      OP_SHL:  alu_res = {ex.b[P_WIDTH-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, ex.b[P_WIDTH-1:1]};
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[P_WIDTH-1], (alu_res == '0), f_flag, (ex.a < ex.b), c_flag};
  end

  // External data is consumed live in EX, so it must be held stable until
  // the retiring edge.
  assign result = ex.data_sel ? I_REGFILE_DATA : alu_res;

  // ---------------- state ----------------
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      ex             <= '0;
      gpr            <= '0;
      O_STATUS_FLAGS <= '0;
    end else if (I_ENABLE) begin
      ex <= id;
      if (ex.vld && !I_FLUSH) begin
        if (ex.reg_write)   gpr[ex.dest]   <= result;
        if (ex.flags_write) O_STATUS_FLAGS <= alu_flags;
      end
    end
  end

  assign O_A            = ex.a;
  assign O_B            = ex.b;
  assign O_RESULT_BUS   = result;
  assign O_REG_DEST     = ex.dest;
  assign O_RESULT_VALID = ex.vld & ~I_FLUSH;

endmodule
